// File: rtl/io_out_sequencer.sv
// Serial-controlled output sequencer for the nine connector output lines.
// Optional watchdog enabled by defining IO_OUT_WDT_EN.
module io_out_sequencer #(
   parameter logic [8:0]  SAFE_VALUE = 9'h000,
   parameter int unsigned WDT_CYCLES = 1000000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       CSN,
   input  logic       SCK,
   input  logic       MOSI,
   output logic [8:0] IO_OUT,
   output logic       FRAME_ERR,
   output logic       WDT_TRIP
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      EXEC
   } state_t;

   localparam logic [2:0] CMD_WRITE  = 3'b001;
   localparam logic [2:0] CMD_COMMIT = 3'b010;
   localparam logic [2:0] CMD_WRCOM  = 3'b011;
   localparam logic [2:0] CMD_SAFE   = 3'b100;

   state_t      state_q, state_d;
   logic [2:0]  csn_q, sck_q;
   logic [1:0]  mosi_q;
   logic [11:0] frame_q, frame_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [8:0]  shadow_q, shadow_d;
   logic [8:0]  out_q, out_d;
   logic        err_q, err_d;
   logic        accept, clr_trip, wdt_fire;
   logic        csn_fall, csn_rise, sck_rise;
   logic [2:0]  cmd;
   logic [8:0]  data;

   // [0],[1] synchronize, [2] holds the previous synchronized value
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         csn_q  <= 3'b111;
         sck_q  <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         csn_q  <= {csn_q[1:0], CSN};
         sck_q  <= {sck_q[1:0], SCK};
         mosi_q <= {mosi_q[0], MOSI};
      end
   end

   assign csn_fall = csn_q[2] & ~csn_q[1];
   assign csn_rise = ~csn_q[2] & csn_q[1];
   assign sck_rise = ~sck_q[2] & sck_q[1];
   assign cmd      = frame_q[11:9];
   assign data     = frame_q[8:0];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         frame_q  <= '0;
         cnt_q    <= '0;
         shadow_q <= SAFE_VALUE;
         out_q    <= SAFE_VALUE;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         out_q    <= wdt_fire ? SAFE_VALUE : out_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      err_d    = 1'b0;
      accept   = 1'b0;
      clr_trip = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (csn_fall) begin
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (sck_rise) begin
               frame_d = {frame_q[10:0], mosi_q[1]};
               if (cnt_q != 4'd13)
                  cnt_d = cnt_q + 4'd1;
            end
            if (csn_rise)
               state_d = EXEC;
         end
         EXEC: begin
            state_d = IDLE;
            if (cnt_q == 4'd12) begin
               accept = 1'b1;
               case (cmd)
                  CMD_WRITE: shadow_d = data;
                  CMD_COMMIT: begin
                     out_d    = shadow_q;
                     clr_trip = 1'b1;
                  end
                  CMD_WRCOM: begin
                     shadow_d = data;
                     out_d    = data;
                     clr_trip = 1'b1;
                  end
                  CMD_SAFE: out_d = SAFE_VALUE;
                  default:  accept = 1'b0;
               endcase
            end
            err_d = ~accept;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef IO_OUT_WDT_EN
   logic [24:0] wdt_q;
   logic        trip_q;
   logic        expire;

   assign expire   = (wdt_q == 25'(WDT_CYCLES - 1));
   // an accepted frame on the expiry cycle takes priority over the trip
   assign wdt_fire = expire & ~accept;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wdt_q  <= '0;
         trip_q <= 1'b0;
      end else begin
         if (accept || expire)
            wdt_q <= '0;
         else
            wdt_q <= wdt_q + 25'd1;
         if (wdt_fire)
            trip_q <= 1'b1;
         else if (clr_trip)
            trip_q <= 1'b0;
      end
   end

   assign WDT_TRIP = trip_q;
`else
   logic wdt_unused;

   assign wdt_unused = (^WDT_CYCLES) ^ clr_trip;
   assign wdt_fire   = 1'b0;
   assign WDT_TRIP   = 1'b0;
`endif

   assign IO_OUT    = out_q;
   assign FRAME_ERR = err_q;

endmodule
